// File: rtl/im_pipe.sv
// im_pipe: instruction memory for the SISC fetch path.
// Pipelined fetch port (RD_LAT cycles, one request per cycle) plus a
// program-load port. A small controller blocks fetch during a load session
// and lets in-flight reads drain before the first write is accepted.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | fetch port open; load_en starts a session
// ST_DRAIN | load requested, waiting for in-flight reads to be delivered
// ST_LOAD  | load session active; load_we writes the array
module im_pipe #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 16,
  parameter int    DEPTH     = 65536,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = "imem_p1.data"
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req,
  input  logic [ADDR_W-1:0] read_addr,
  output logic              rdy,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy,
  output logic [ADDR_W:0]   load_count,
  output logic              addr_err
);

  localparam int             IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pe;
  logic [DATA_W-1:0] pd [RD_LAT];

  logic accept;
  logic rd_in_range;
  logic ld_in_range;
  logic ld_active;
  logic wr_en;
  logic ld_err_q;
  logic pending;
  logic enter_load;

  // Reads that will still produce a read_valid after the coming edge;
  // the output stage is being delivered this cycle and does not count.
  if (RD_LAT > 1) begin : g_pend
    assign pending = |pv[RD_LAT-2:0];
  end else begin : g_nopend
    assign pending = 1'b0;
  end

  assign rdy         = (state == ST_IDLE) && !load_en;
  assign accept      = req && rdy;
  assign rd_in_range = {1'b0, read_addr} < DEPTH_V;
  assign ld_in_range = {1'b0, load_addr} < DEPTH_V;
  // A write on the edge that leaves LOAD (load_en already low) is dropped
  assign ld_active   = (state == ST_LOAD) && load_en && load_we;
  assign wr_en       = ld_active && ld_in_range;
  assign enter_load  = (state != ST_LOAD) && (state_nxt == ST_LOAD);

  assign busy       = (state != ST_IDLE);
  assign read_valid = pv[RD_LAT-1];
  assign read_data  = pd[RD_LAT-1];
  assign addr_err   = (pv[RD_LAT-1] && pe[RD_LAT-1]) || ld_err_q;

  // Controller state register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Controller next-state: load_en dropping always returns to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (load_en) state_nxt = pending ? ST_DRAIN : ST_LOAD;
      end
      ST_DRAIN: begin
        if (!load_en)     state_nxt = ST_IDLE;
        else if (!pending) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (!load_en) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Fetch pipeline: stage 0 reads the array, later stages only delay.
  // Data/error stages load only with a valid so read_data holds when idle.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < RD_LAT; i++) pd[i] <= '0;
    end else begin
      pv[0] <= accept;
      if (accept) begin
        pe[0] <= !rd_in_range;
        pd[0] <= rd_in_range ? mem[read_addr[IDX_W-1:0]] : '0;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pe[i] <= pe[i-1];
          pd[i] <= pd[i-1];
        end
      end
    end
  end

  // Program-load write port; contents survive rst_f
  always_ff @(posedge clk) begin
    if (wr_en) mem[load_addr[IDX_W-1:0]] <= load_data;
  end

  // Session word counter (saturating) and out-of-range write flag
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      load_count <= '0;
      ld_err_q   <= 1'b0;
    end else begin
      ld_err_q <= ld_active && !ld_in_range;
      if (enter_load)
        load_count <= '0;
      else if (wr_en && (load_count != CNT_MAX))
        load_count <= load_count + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_im_pipe.sv
// Bench for im_pipe: two instances (RD_LAT=1/full depth and RD_LAT=3/DEPTH=256)
// share one stimulus stream and are compared every cycle against a
// transaction-level model (response list with due cycles, word map).
module tb_im_pipe;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        req, load_en, load_we;
  logic [15:0] read_addr, load_addr;
  logic [31:0] load_data;

  logic        rdy_o  [2];
  logic        rv_o   [2];
  logic        busy_o [2];
  logic        err_o  [2];
  logic [31:0] rd_o   [2];
  logic [16:0] cnt_o  [2];

  always #5 clk = ~clk;

  im_pipe #(.DATA_W(32), .ADDR_W(16), .DEPTH(65536), .RD_LAT(1), .INIT_FILE("")) u_lat1 (
    .clk(clk), .rst_f(rst_f), .req(req), .read_addr(read_addr), .rdy(rdy_o[0]),
    .read_data(rd_o[0]), .read_valid(rv_o[0]), .load_en(load_en), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .busy(busy_o[0]),
    .load_count(cnt_o[0]), .addr_err(err_o[0]));

  im_pipe #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .RD_LAT(3), .INIT_FILE("")) u_lat3 (
    .clk(clk), .rst_f(rst_f), .req(req), .read_addr(read_addr), .rdy(rdy_o[1]),
    .read_data(rd_o[1]), .read_valid(rv_o[1]), .load_en(load_en), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .busy(busy_o[1]),
    .load_count(cnt_o[1]), .addr_err(err_o[1]));

  typedef struct {
    int          inst;
    int          due;
    logic [31:0] data;
    bit          err;
  } resp_t;

  resp_t       rq [$];
  logic [31:0] mem0 [int];
  logic [31:0] mem1 [int];
  int          m_st   [2];   // 0 open for fetch, 1 waiting for reads, 2 loading
  logic [16:0] m_cnt  [2];
  logic [31:0] m_last [2];
  bit          m_lerr [2];
  int          n_cyc;
  int          n_cmp, n_bad;

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int depth_of(int k);
    return (k == 0) ? 65536 : 256;
  endfunction

  function automatic logic [31:0] mrd(int k, int a);
    if (k == 0) return mem0.exists(a) ? mem0[a] : 32'h0;
    return mem1.exists(a) ? mem1[a] : 32'h0;
  endfunction

  function automatic logic [15:0] pick();
    int r;
    r = $urandom_range(0, 39);
    return (r < 32) ? 16'(r) : 16'(256 + r - 32);
  endfunction

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s lat%0d cyc %0d: got %0h expected %0h", tag, lat_of(k), n_cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      bit          v = 1'b0;
      bit          e = 1'b0;
      logic [31:0] d = m_last[k];
      foreach (rq[i]) begin
        if (rq[i].inst == k && rq[i].due == n_cyc) begin
          v = 1'b1;
          d = rq[i].data;
          e = rq[i].err;
        end
      end
      chk("rdy",        k, 32'(rdy_o[k]),  32'(m_st[k] == 0 && !load_en));
      chk("busy",       k, 32'(busy_o[k]), 32'(m_st[k] != 0));
      chk("read_valid", k, 32'(rv_o[k]),   32'(v));
      chk("read_data",  k, rd_o[k],        d);
      chk("addr_err",   k, 32'(err_o[k]),  32'((v && e) || m_lerr[k]));
      chk("load_count", k, 32'(cnt_o[k]),  32'(m_cnt[k]));
    end
  endtask

  // Advance the model across the rising edge that ends cycle n_cyc
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int D = depth_of(k);
      bit ld = (m_st[k] == 2) && load_en && load_we;
      bit pend = 1'b0;
      bit inr;
      m_lerr[k] = ld && (int'(load_addr) >= D);
      if (ld && int'(load_addr) < D) begin
        if (k == 0) mem0[int'(load_addr)] = load_data;
        else        mem1[int'(load_addr)] = load_data;
        if (m_cnt[k] != 17'h10000) m_cnt[k] = m_cnt[k] + 17'd1;
      end
      if (m_st[k] == 0 && !load_en && req) begin
        inr = int'(read_addr) < D;
        rq.push_back('{k, n_cyc + lat_of(k), inr ? mrd(k, int'(read_addr)) : 32'h0, !inr});
      end
      foreach (rq[i]) begin
        if (rq[i].inst == k && rq[i].due > n_cyc) pend = 1'b1;
        if (rq[i].inst == k && rq[i].due == n_cyc) m_last[k] = rq[i].data;
      end
      case (m_st[k])
        0: if (load_en) m_st[k] = pend ? 1 : 2;
        1: if (!load_en) m_st[k] = 0; else if (!pend) m_st[k] = 2;
        default: if (!load_en) m_st[k] = 0;
      endcase
      if (m_st[k] == 2 && !(ld || (m_st[k] == 2 && load_en && !load_we)) && 0) m_cnt[k] = m_cnt[k];
    end
    for (int i = rq.size() - 1; i >= 0; i--)
      if (rq[i].due == n_cyc) rq.delete(i);
  endtask

  task automatic step();
    int prev [2];
    @(negedge clk);
    check_outputs();
    prev[0] = m_st[0];
    prev[1] = m_st[1];
    model_edge();
    for (int k = 0; k < 2; k++)
      if (prev[k] != 2 && m_st[k] == 2) m_cnt[k] = 17'd0;
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic hw_reset();
    rst_f = 1'b0;
    #1;
    rq.delete();
    for (int k = 0; k < 2; k++) begin
      m_st[k]   = 0;
      m_cnt[k]  = 17'd0;
      m_last[k] = 32'h0;
      m_lerr[k] = 1'b0;
      chk("rst_read_valid", k, 32'(rv_o[k]),   32'h0);
      chk("rst_read_data",  k, rd_o[k],        32'h0);
      chk("rst_busy",       k, 32'(busy_o[k]), 32'h0);
      chk("rst_addr_err",   k, 32'(err_o[k]),  32'h0);
      chk("rst_load_count", k, 32'(cnt_o[k]),  32'h0);
      chk("rst_rdy",        k, 32'(rdy_o[k]),  32'(!load_en));
    end
    req = 1'b0; load_en = 1'b0; load_we = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic load_begin();
    req = 1'b0; load_we = 1'b0; load_en = 1'b1;
    step();
  endtask

  task automatic load_write(logic [15:0] a, logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    step();
    load_we = 1'b0;
  endtask

  // load_en falls together with a write strobe that must be ignored
  task automatic load_end();
    load_en = 1'b0; load_we = 1'b1; load_addr = 16'h0005; load_data = $urandom;
    step();
    load_we = 1'b0;
  endtask

  task automatic fetch(logic [15:0] a);
    req = 1'b1; read_addr = a;
    step();
    req = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_cyc = 0;
    rst_f = 1'b1; req = 1'b0; load_en = 1'b0; load_we = 1'b0;
    read_addr = '0; load_addr = '0; load_data = '0;
    #1;
    hw_reset();
    idle(1);

    // Image at 0..2 plus a pool of words; 0x100.. is out of range for DEPTH=256
    load_begin();
    load_write(16'h0000, 32'h11111111);
    load_write(16'h0001, 32'h22222222);
    load_write(16'h0002, 32'h33333333);
    for (int a = 3; a < 32; a++) load_write(16'(a), $urandom);
    for (int a = 256; a < 264; a++) load_write(16'(a), $urandom);
    load_end();
    idle(2);

    // Back-to-back fetches at full throughput
    fetch(16'h0000); fetch(16'h0001); fetch(16'h0002);
    idle(4);

    // Short session then read back
    load_begin();
    load_write(16'h0010, 32'hDEADBEEF);
    load_write(16'h0011, 32'h12345678);
    load_end();
    fetch(16'h0010); fetch(16'h0011);
    idle(4);

    // Boundary fetch at 0x0100
    fetch(16'h0100);
    idle(4);

    // Drain: two reads in flight, load_en arrives with req still held
    req = 1'b1; read_addr = 16'h0003; step();
    read_addr = 16'h0004; step();
    load_en = 1'b1; read_addr = 16'h0007;
    repeat (4) step();
    req = 1'b0;
    load_write(16'h0008, $urandom);
    load_write(16'h0100, $urandom);
    load_end();
    idle(4);

    // Drain abandoned when load_en falls first
    req = 1'b1; read_addr = 16'h0001; step();
    read_addr = 16'h0002; step();
    req = 1'b0; load_en = 1'b1; step();
    load_en = 1'b0; step();
    idle(4);

    // Reset mid-LOAD after one write; the written word persists
    load_begin();
    load_write(16'h0005, 32'hA5A55A5A);
    load_en = 1'b1;
    hw_reset();
    idle(1);
    fetch(16'h0005);
    idle(4);

    // Reset mid-DRAIN discards the in-flight reads
    req = 1'b1; read_addr = 16'h0006; step();
    read_addr = 16'h0007; step();
    req = 1'b0; load_en = 1'b1; step();
    hw_reset();
    idle(5);

    // Random traffic with occasional load sessions
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) load_en = ~load_en;
      req       = 1'($urandom_range(0, 1));
      read_addr = pick();
      load_we   = 1'($urandom_range(0, 1));
      load_addr = pick();
      load_data = $urandom;
      step();
    end
    req = 1'b0; load_en = 1'b0; load_we = 1'b0;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
